mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and register-write width.
REQ-002 SHALL have parameter REGW, default 5: register address width.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 stall_i  in  1  hold the WB pipeline register and the retire counter.
REQ-006 flush_i  in  1  load a bubble into the WB pipeline register.
REQ-007 valid_i  in  1  the MEM-stage instruction is valid.
REQ-008 reg_we_i  in  1  the instruction writes rd.
REQ-009 rd_i  in  REGW  destination register address.
REQ-010 wb_sel_i  in  2  write source: 0 ALU, 1 load, 2 PC+4, 3 CSR.
REQ-011 funct3_i  in  3  load type (RV32I funct3 encoding).
REQ-012 alu_res_i  in  XLEN  ALU result; bits [1:0] are also the load byte offset.
REQ-013 load_data_i  in  XLEN  raw aligned data-memory read word.
REQ-014 pc_i  in  XLEN  instruction PC.
REQ-015 csr_rdata_i  in  XLEN  CSR read data.
REQ-016 we_o  out  1  register-file write enable.
REQ-017 waddr_o  out  REGW  register-file write address.
REQ-018 wdata_o  out  XLEN  register-file write data.
REQ-019 wb_valid_o  out  1  the WB stage holds a valid instruction (used by hazard and forwarding logic).
REQ-020 instret_o  out  64  count of retired instructions.

Function
REQ-021 SHALL hold one pipeline register set: valid, reg_we, rd, wb_sel, funct3, alu_res, load_data, pc, csr_rdata.
REQ-022 On each rising edge, update priority is: flush_i (valid<=0, reg_we<=0, other fields don't-care), then stall_i (hold all fields), else capture all inputs.
REQ-023 Latency: an instruction presented with stall_i=0 and flush_i=0 SHALL appear on the WB outputs in the next cycle.
REQ-024 wdata_o, we_o and waddr_o SHALL be combinational from the registered fields only, never from the inputs directly.
REQ-025 we_o SHALL be valid AND reg_we AND (rd != 0); waddr_o SHALL be the registered rd.
REQ-026 wdata_o by wb_sel: 0 -> alu_res; 1 -> aligned load value; 2 -> pc+4, modulo 2^XLEN; 3 -> csr_rdata.
REQ-027 Load alignment with off = alu_res[1:0]:
  - LB (000): byte = word[8*off+7 : 8*off], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): halfword = word[16*off[1]+15 : 16*off[1]], sign-extended; off[0] ignored.
  - LHU (101): same halfword, zero-extended.
  - LW (010) and codes 011, 110, 111: the full word, offset ignored.
REQ-028 A stalled WB instruction SHALL keep driving identical we_o, waddr_o and wdata_o; repeated register-file writes of the same value are permitted.
REQ-029 instret_o SHALL increment by 1 on a rising edge where registered valid=1 and stall_i=0, so that each instruction counts exactly once.
REQ-030 instret_o SHALL wrap from 2^64-1 to 0.
REQ-031 A flushed slot SHALL neither write the register file nor increment instret_o.
REQ-032 flush_i and stall_i asserted together SHALL insert a bubble and SHALL NOT increment the counter for the instruction that was held.

Reset
REQ-033 While rst_i=1: valid, reg_we, and all datapath fields SHALL be 0, and instret_o SHALL be 0, independent of the clock.
REQ-034 During reset, outputs SHALL be we_o=0, waddr_o=0, wdata_o=0 (wb_sel=0, alu_res=0), and wb_valid_o=0.
REQ-035 Reset asserted mid-stall or mid-flush SHALL override both; the first capture SHALL occur at the first rising edge after rst_i falls.

Verification
REQ-036 ALU write: rd=5, wb_sel=0, alu_res=0x0000_1234 -> next cycle we_o=1, waddr_o=5, wdata_o=0x0000_1234; instret_o increments by 1.
REQ-037 Loads with word 0x8070_F0A5:
  - LB off=0 -> 0xFFFF_FFA5.
  - LBU off=1 -> 0x0000_00F0.
  - LH off=2 -> 0xFFFF_8070.
  - LHU off=3 -> 0x0000_8070.
  - LW -> 0x8070_F0A5.
REQ-038 rd=0 with reg_we=1 and valid=1 -> we_o=0, while instret_o still increments.
REQ-039 JAL-style write: wb_sel=2, pc=0xFFFF_FFFC -> wdata_o=0x0000_0000. CSR write: wb_sel=3, csr_rdata=0xDEAD_BEEF -> wdata_o=0xDEAD_BEEF.
REQ-040 Stall and flush sequencing:
  - Stall for 3 cycles -> outputs frozen and instret_o unchanged.
  - Release stall -> instret_o +1 once.
  - flush_i with stall_i -> wb_valid_o=0 next cycle.
REQ-041 Async reset and counter wrap:
  - rst_i pulsed between clock edges with instret_o=7 -> instret_o=0 and we_o=0 immediately.
  - Counter preloaded to 0xFFFF_FFFF_FFFF_FFFF, then one retire -> instret_o=0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: pipeline control, MEM-stage payload, and register-file write port.
// The master drives the stage inputs; the slave (the WB stage) drives the results.
interface mem_wb_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            stall_i;
  logic            flush_i;
  logic            valid_i;
  logic            reg_we_i;
  logic [REGW-1:0] rd_i;
  logic [1:0]      wb_sel_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] alu_res_i;
  logic [XLEN-1:0] load_data_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] csr_rdata_i;

  logic            we_o;
  logic [REGW-1:0] waddr_o;
  logic [XLEN-1:0] wdata_o;
  logic            wb_valid_o;
  logic [63:0]     instret_o;

  modport master (
    output stall_i, flush_i, valid_i, reg_we_i, rd_i, wb_sel_i, funct3_i,
    output alu_res_i, load_data_i, pc_i, csr_rdata_i,
    input  we_o, waddr_o, wdata_o, wb_valid_o, instret_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, reg_we_i, rd_i, wb_sel_i, funct3_i,
    input  alu_res_i, load_data_i, pc_i, csr_rdata_i,
    output we_o, waddr_o, wdata_o, wb_valid_o, instret_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, write-back mux and a 64-bit retire counter.
// Register-file write signals are decoded only from registered fields.
module mem_wb_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_wb_stage_if.slave wb_if
);

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  logic            r_valid;
  logic            r_reg_we;
  logic [REGW-1:0] r_rd;
  logic [1:0]      r_wb_sel;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu_res;
  logic [XLEN-1:0] r_load_data;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_csr_rdata;
  logic [63:0]     r_instret;

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_wdata;

  // Flush beats stall; a held instruction retires only on the edge that releases it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_reg_we    <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_funct3    <= '0;
      r_alu_res   <= '0;
      r_load_data <= '0;
      r_pc        <= '0;
      r_csr_rdata <= '0;
      r_instret   <= '0;
    end else begin
      if (wb_if.flush_i) begin
        r_valid  <= 1'b0;
        r_reg_we <= 1'b0;
      end else if (!wb_if.stall_i) begin
        r_valid     <= wb_if.valid_i;
        r_reg_we    <= wb_if.reg_we_i;
        r_rd        <= wb_if.rd_i;
        r_wb_sel    <= wb_if.wb_sel_i;
        r_funct3    <= wb_if.funct3_i;
        r_alu_res   <= wb_if.alu_res_i;
        r_load_data <= wb_if.load_data_i;
        r_pc        <= wb_if.pc_i;
        r_csr_rdata <= wb_if.csr_rdata_i;
      end
      if (r_valid && !wb_if.stall_i) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  always_comb begin
    w_off = r_alu_res[1:0];
    unique case (w_off)
      2'd0:    w_byte = r_load_data[7:0];
      2'd1:    w_byte = r_load_data[15:8];
      2'd2:    w_byte = r_load_data[23:16];
      default: w_byte = r_load_data[31:24];
    endcase
    w_half = w_off[1] ? r_load_data[31:16] : r_load_data[15:0];

    // Codes other than the four narrow loads return the full word.
    case (r_funct3)
      F3Lb:    w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3Lbu:   w_load_val = {{(XLEN-8){1'b0}}, w_byte};
      F3Lh:    w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
      F3Lhu:   w_load_val = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_val = r_load_data;
    endcase

    unique case (r_wb_sel)
      2'd0:    w_wdata = r_alu_res;
      2'd1:    w_wdata = w_load_val;
      2'd2:    w_wdata = r_pc + XLEN'(4);
      default: w_wdata = r_csr_rdata;
    endcase
  end

  assign wb_if.we_o       = r_valid & r_reg_we & (r_rd != '0);
  assign wb_if.waddr_o    = r_rd;
  assign wb_if.wdata_o    = w_wdata;
  assign wb_if.wb_valid_o = r_valid;
  assign wb_if.instret_o  = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected WB results are queued at drive time
// and popped one cycle later when the stage presents them.
module tb_mem_wb_stage;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        valid;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic        m_valid;
  logic [63:0] exp_instret;
  logic [63:0] snap;

  mem_wb_stage_if #(.XLEN(32), .REGW(5)) bus ();

  mem_wb_stage #(.XLEN(32), .REGW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(input logic [1:0] sel, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] ld,
                                              input logic [31:0] pc, input logic [31:0] csr);
    logic [31:0] sh;
    logic [31:0] ld_val;
    sh = ld >> (8 * alu[1:0]);
    case (f3)
      3'b000:  ld_val = 32'($signed(sh[7:0]));
      3'b100:  ld_val = {24'd0, sh[7:0]};
      3'b001:  begin sh = ld >> (16 * alu[1]); ld_val = 32'($signed(sh[15:0])); end
      3'b101:  begin sh = ld >> (16 * alu[1]); ld_val = {16'd0, sh[15:0]}; end
      default: ld_val = ld;
    endcase
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld_val;
      2'd2:    return pc + 32'd4;
      default: return csr;
    endcase
  endfunction

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc, input logic [31:0] csr, input logic stall,
                       input logic flush);
    bus.valid_i     = v;
    bus.reg_we_i    = we;
    bus.rd_i        = rd;
    bus.wb_sel_i    = sel;
    bus.funct3_i    = f3;
    bus.alu_res_i   = alu;
    bus.load_data_i = ld;
    bus.pc_i        = pc;
    bus.csr_rdata_i = csr;
    bus.stall_i     = stall;
    bus.flush_i     = flush;
  endtask

  task automatic drive_rand(input logic stall, input logic flush);
    drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
          $urandom, stall, flush);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".we"}, 64'(bus.we_o), 64'(e.we));
    check({tag, ".waddr"}, 64'(bus.waddr_o), 64'(e.waddr));
    check({tag, ".wdata"}, 64'(bus.wdata_o), 64'(e.wdata));
    check({tag, ".valid"}, 64'(bus.wb_valid_o), 64'(e.valid));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".we"}, 64'(bus.we_o), 64'd0);
    check({tag, ".waddr"}, 64'(bus.waddr_o), 64'd0);
    check({tag, ".wdata"}, 64'(bus.wdata_o), 64'd0);
    check({tag, ".valid"}, 64'(bus.wb_valid_o), 64'd0);
    check({tag, ".instret"}, bus.instret_o, 64'd0);
  endtask

  // Drives one instruction at the falling edge (also releasing reset), then checks it after
  // the next rising edge.
  task automatic issue(input string tag, input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc, input logic [31:0] csr);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    drive(v, we, rd, sel, f3, alu, ld, pc, csr, 1'b0, 1'b0);
    e.valid = v;
    e.we    = v && we && (rd != 5'd0);
    e.waddr = rd;
    e.wdata = model_wdata(sel, f3, alu, ld, pc, csr);
    sb_q.push_back(e);
    @(posedge clk);
    exp_instret = exp_instret + 64'(m_valid);
    m_valid     = v;
    #1;
    e = sb_q.pop_front();
    check_outputs(tag, e);
    check({tag, ".instret"}, bus.instret_o, exp_instret);
    last_exp = e;
  endtask

  task automatic stall_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_rand(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("stall", last_exp);
      check("stall.instret", bus.instret_o, exp_instret);
    end
  endtask

  task automatic flush_cycle(input string tag, input logic stall);
    @(negedge clk);
    drive_rand(stall, 1'b1);
    @(posedge clk);
    if (!stall) exp_instret = exp_instret + 64'(m_valid);
    m_valid = 1'b0;
    #1;
    check({tag, ".valid"}, 64'(bus.wb_valid_o), 64'd0);
    check({tag, ".we"}, 64'(bus.we_o), 64'd0);
    check({tag, ".instret"}, bus.instret_o, exp_instret);
    last_exp.valid = 1'b0;
    last_exp.we    = 1'b0;
  endtask

  initial begin
    m_valid     = 1'b0;
    exp_instret = '0;
    last_exp    = '{we: 1'b0, waddr: 5'd0, wdata: 32'd0, valid: 1'b0};
    rst         = 1'b1;
    drive_rand(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_hold");

    issue("alu", 1, 1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    issue("lb0", 1, 1, 5'd6, 2'd1, 3'b000, 32'h0000_1000, 32'h8070_F0A5, 0, 0);
    check("lb0.val", 64'(bus.wdata_o), 64'hFFFF_FFA5);
    issue("lbu1", 1, 1, 5'd7, 2'd1, 3'b100, 32'h0000_1001, 32'h8070_F0A5, 0, 0);
    check("lbu1.val", 64'(bus.wdata_o), 64'h0000_00F0);
    issue("lh2", 1, 1, 5'd8, 2'd1, 3'b001, 32'h0000_1002, 32'h8070_F0A5, 0, 0);
    check("lh2.val", 64'(bus.wdata_o), 64'hFFFF_8070);
    issue("lhu3", 1, 1, 5'd9, 2'd1, 3'b101, 32'h0000_1003, 32'h8070_F0A5, 0, 0);
    check("lhu3.val", 64'(bus.wdata_o), 64'h0000_8070);
    issue("lw", 1, 1, 5'd10, 2'd1, 3'b010, 32'h0000_1001, 32'h8070_F0A5, 0, 0);
    check("lw.val", 64'(bus.wdata_o), 64'h8070_F0A5);
    issue("f3_111", 1, 1, 5'd11, 2'd1, 3'b111, 32'h0000_1002, 32'h8070_F0A5, 0, 0);
    snap = exp_instret;
    issue("rd0", 1, 1, 5'd0, 2'd0, 3'd0, 32'h0000_00FF, 0, 0, 0);
    issue("after_rd0", 0, 0, 5'd1, 2'd0, 3'd0, 32'h0, 0, 0, 0);
    check("rd0.counted", bus.instret_o, snap + 64'd2);
    issue("jal", 1, 1, 5'd1, 2'd2, 3'd0, 32'h0, 0, 32'hFFFF_FFFC, 0);
    check("jal.val", 64'(bus.wdata_o), 64'h0);
    issue("csr", 1, 1, 5'd12, 2'd3, 3'd0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    check("csr.val", 64'(bus.wdata_o), 64'hDEAD_BEEF);

    for (int i = 0; i < 24; i++) begin
      issue("rand", 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom);
    end

    // Stall holds outputs and counter; release retires the held instruction exactly once.
    issue("pre_stall", 1, 1, 5'd13, 2'd1, 3'b000, 32'h3, 32'h8070_F0A5, 0, 0);
    snap = exp_instret;
    stall_cycles(3);
    issue("stall_rel", 0, 0, 5'd0, 2'd0, 3'd0, 0, 0, 0, 0);
    check("stall_rel.inc", bus.instret_o, snap + 64'd1);

    issue("pre_fs", 1, 1, 5'd14, 2'd0, 3'd0, 32'h55, 0, 0, 0);
    flush_cycle("flush_stall", 1'b1);
    issue("pre_f", 1, 1, 5'd15, 2'd0, 3'd0, 32'h66, 0, 0, 0);
    flush_cycle("flush_only", 1'b0);
    issue("post_f", 0, 0, 5'd0, 2'd0, 3'd0, 0, 0, 0, 0);

    // Async reset between edges with instret at 7, held across stall+flush.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #3;
    m_valid     = 1'b0;
    exp_instret = '0;
    for (int i = 0; i < 8; i++) begin
      issue("pre_rst", 1, 1, 5'(i + 1), 2'd0, 3'd0, 32'(i), 0, 0, 0);
    end
    check("pre_rst.seven", bus.instret_o, 64'd7);
    #3;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    drive_rand(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_over_stall_flush");
    m_valid     = 1'b0;
    exp_instret = '0;
    issue("first_capture", 1, 1, 5'd3, 2'd3, 3'd0, 0, 0, 0, 32'hCAFE_F00D);

    // Preload the counter to all ones; the pending retire must wrap it to zero.
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check("preload", bus.instret_o, exp_instret);
    issue("wrap", 0, 0, 5'd0, 2'd0, 3'd0, 0, 0, 0, 0);
    check("wrap.zero", bus.instret_o, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
